// File: rtl/axi4_bram_bridge_if.sv
// AXI4 slave-side channel bundle (AW/W/B/AR/R) between a host and axi4_bram_bridge.
// The slave modport is the bridge view; the master modport is the host view.
interface axi4_bram_bridge_if #(
    parameter int ADDR_W = 22,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   s_awaddr;
    logic [7:0]          s_awlen;
    logic                s_awvalid;
    logic                s_awready;
    logic [DATA_W-1:0]   s_wdata;
    logic [DATA_W/8-1:0] s_wstrb;
    logic                s_wlast;
    logic                s_wvalid;
    logic                s_wready;
    logic [1:0]          s_bresp;
    logic                s_bvalid;
    logic                s_bready;
    logic [ADDR_W-1:0]   s_araddr;
    logic [7:0]          s_arlen;
    logic                s_arvalid;
    logic                s_arready;
    logic [DATA_W-1:0]   s_rdata;
    logic [1:0]          s_rresp;
    logic                s_rlast;
    logic                s_rvalid;
    logic                s_rready;

    modport slave (
        input  s_awaddr, s_awlen, s_awvalid,
        output s_awready,
        input  s_wdata, s_wstrb, s_wlast, s_wvalid,
        output s_wready,
        output s_bresp, s_bvalid,
        input  s_bready,
        input  s_araddr, s_arlen, s_arvalid,
        output s_arready,
        output s_rdata, s_rresp, s_rlast, s_rvalid,
        input  s_rready
    );

    modport master (
        output s_awaddr, s_awlen, s_awvalid,
        input  s_awready,
        output s_wdata, s_wstrb, s_wlast, s_wvalid,
        input  s_wready,
        input  s_bresp, s_bvalid,
        output s_bready,
        output s_araddr, s_arlen, s_arvalid,
        input  s_arready,
        input  s_rdata, s_rresp, s_rlast, s_rvalid,
        output s_rready
    );
endinterface

// File: rtl/axi4_bram_bridge.sv
// AXI4 INCR-burst slave to BRAM word port, one transaction in flight; write beat 1 cycle,
// read beat RD_LATENCY+2 cycles; W/R beats stall on wvalid/rready, B holds until bready.
module axi4_bram_bridge #(
    parameter int ADDR_W     = 22,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst,
    axi4_bram_bridge_if.slave   s,
    output logic [ADDR_W-1:0]   addr_a,
    output logic [DATA_W-1:0]   wrdata_a,
    input  logic [DATA_W-1:0]   rddata_a,
    output logic                en_a,
    output logic [DATA_W/8-1:0] we_a,
    output logic                rst_a
);
    localparam int SW = DATA_W / 8;
    localparam int LW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [2:0] {IDLE, WR_DATA, WR_RESP, RD_ISSUE, RD_WAIT, RD_DATA} state_t;

    state_t            state_q, state_d;
    logic              awready_q, awready_d, arready_q, arready_d;
    logic              wready_q, wready_d, bvalid_q, bvalid_d;
    logic              rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [1:0]        bresp_q, bresp_d, rresp_q, rresp_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [7:0]        len_q, len_d, cnt_q, cnt_d;
    logic              aerr_q, aerr_d, perr_q, perr_d;
    logic              wdone_q, wdone_d, prio_wr_q, prio_wr_d;
    logic [LW-1:0]     lat_q, lat_d;
    logic              en_q, en_d;
    logic [SW-1:0]     we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdat_q, wdat_d;
    logic              aw_hs, ar_hs, w_hs, b_hs, r_hs, last_beat, aw_sel;

    assign aw_hs     = (state_q == IDLE) && awready_q && s.s_awvalid;
    assign ar_hs     = (state_q == IDLE) && arready_q && s.s_arvalid;
    assign w_hs      = wready_q && s.s_wvalid;
    assign b_hs      = bvalid_q && s.s_bready;
    assign r_hs      = rvalid_q && s.s_rready;
    assign last_beat = (cnt_q == len_q);

    always_comb begin
        state_d   = state_q;
        rresp_d   = rresp_q;
        bresp_d   = bresp_q;
        rdata_d   = rdata_q;
        cur_d     = cur_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        aerr_d    = aerr_q;
        perr_d    = perr_q;
        wdone_d   = wdone_q;
        prio_wr_d = prio_wr_q;
        lat_d     = lat_q;
        en_d      = 1'b0;
        we_d      = '0;
        addr_d    = addr_q;
        wdat_d    = wdat_q;
        aw_sel    = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Only one ready is ever offered, so a grant is always a single handshake.
                // The priority flag names the loser of the last contested grant.
                if (aw_hs) begin
                    cur_d   = s.s_awaddr;
                    len_d   = s.s_awlen;
                    cnt_d   = '0;
                    aerr_d  = |s.s_awaddr[1:0];
                    perr_d  = 1'b0;
                    wdone_d = 1'b0;
                    state_d = WR_DATA;
                    if (s.s_arvalid) prio_wr_d = 1'b0;
                end else if (ar_hs) begin
                    cur_d   = s.s_araddr;
                    len_d   = s.s_arlen;
                    cnt_d   = '0;
                    aerr_d  = |s.s_araddr[1:0];
                    rresp_d = (|s.s_araddr[1:0]) ? SLVERR : OKAY;
                    if (|s.s_araddr[1:0]) begin
                        rdata_d = '0;
                        state_d = RD_DATA;
                    end else begin
                        state_d = RD_ISSUE;
                    end
                    if (s.s_awvalid) prio_wr_d = 1'b1;
                end
            end
            WR_DATA: begin
                if (wdone_q) begin
                    bresp_d = (aerr_q || perr_q) ? SLVERR : OKAY;
                    state_d = WR_RESP;
                end else if (w_hs) begin
                    if (!aerr_q) begin
                        en_d   = 1'b1;
                        we_d   = s.s_wstrb;
                        addr_d = cur_q;
                        wdat_d = s.s_wdata;
                    end
                    cur_d = cur_q + ADDR_W'(4);
                    if (s.s_wlast != last_beat) perr_d = 1'b1;
                    if (last_beat) wdone_d = 1'b1;
                    else           cnt_d   = cnt_q + 8'd1;
                end
            end
            WR_RESP: begin
                if (b_hs) state_d = IDLE;
            end
            RD_ISSUE: begin
                lat_d   = '0;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (lat_q == LW'(RD_LATENCY - 1)) begin
                    rdata_d = rddata_a;
                    state_d = RD_DATA;
                end else begin
                    lat_d = lat_q + LW'(1);
                end
            end
            RD_DATA: begin
                if (r_hs) begin
                    cur_d = cur_q + ADDR_W'(4);
                    cnt_d = cnt_q + 8'd1;
                    if (last_beat)   state_d = IDLE;
                    else if (aerr_q) state_d = RD_DATA;
                    else             state_d = RD_ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase

        // The read port is driven from the first cycle of RD_ISSUE until the capture cycle.
        if (state_d == RD_ISSUE) begin
            en_d   = 1'b1;
            addr_d = cur_d;
        end else if (state_d == RD_WAIT) begin
            en_d = 1'b1;
        end

        if (s.s_awvalid && !s.s_arvalid)      aw_sel = 1'b1;
        else if (s.s_arvalid && !s.s_awvalid) aw_sel = 1'b0;
        else                                  aw_sel = prio_wr_d;

        awready_d = (state_d == IDLE) && aw_sel;
        arready_d = (state_d == IDLE) && !aw_sel;
        wready_d  = (state_d == WR_DATA) && !wdone_d;
        bvalid_d  = (state_d == WR_RESP);
        rvalid_d  = (state_d == RD_DATA);
        rlast_d   = (state_d == RD_DATA) && (cnt_d == len_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            awready_q <= 1'b0;
            arready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            bresp_q   <= OKAY;
            rresp_q   <= OKAY;
            rdata_q   <= '0;
            cur_q     <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            aerr_q    <= 1'b0;
            perr_q    <= 1'b0;
            wdone_q   <= 1'b0;
            prio_wr_q <= 1'b1;
            lat_q     <= '0;
            en_q      <= 1'b0;
            we_q      <= '0;
            addr_q    <= '0;
            wdat_q    <= '0;
        end else begin
            state_q   <= state_d;
            awready_q <= awready_d;
            arready_q <= arready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            bresp_q   <= bresp_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            cur_q     <= cur_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            aerr_q    <= aerr_d;
            perr_q    <= perr_d;
            wdone_q   <= wdone_d;
            prio_wr_q <= prio_wr_d;
            lat_q     <= lat_d;
            en_q      <= en_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdat_q    <= wdat_d;
        end
    end

    assign s.s_awready = awready_q;
    assign s.s_arready = arready_q;
    assign s.s_wready  = wready_q;
    assign s.s_bvalid  = bvalid_q;
    assign s.s_bresp   = bresp_q;
    assign s.s_rvalid  = rvalid_q;
    assign s.s_rlast   = rlast_q;
    assign s.s_rresp   = rresp_q;
    assign s.s_rdata   = rdata_q;
    assign en_a        = en_q;
    assign we_a        = we_q;
    assign addr_a      = addr_q;
    assign wrdata_a    = wdat_q;
    assign rst_a       = rst;
endmodule
